// File: rtl/counter_updown_n.sv
`default_nettype none
// ============================================================================
//  Module      : counter_updown_n
//  Description : Parametrised up/down counter with programmable modulus,
//                parallel load (clamped to MAX_VALUE), synchronous clear,
//                combinational terminal-count detect and sticky wrap flag.
//                Optional feature macro: COUNTER_SAT_EN adds a `saturate`
//                input that makes the counter hold at its bounds.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_updown_n #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
`ifdef COUNTER_SAT_EN
    input  logic             saturate,
`endif
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             up_down,
    input  logic             enable,
    input  logic             load,
    input  logic             clear,
    output logic [WIDTH-1:0] result,
    output logic             terminal_count,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] c_MAX  = MAX_VALUE;
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrapped_nxt;
    logic [WIDTH-1:0] w_load_val;
    logic             w_at_bound;
    logic             w_sat;

`ifdef COUNTER_SAT_EN
    assign w_sat = saturate;
`else
    assign w_sat = 1'b0;
`endif

    // A load value above the top of the range is clamped so that the count
    // never leaves 0..MAX_VALUE.
    assign w_load_val = (data > c_MAX) ? c_MAX : data;

    // Sitting on the bound in the current direction: the next step wraps
    // (or holds, when saturating).
    assign w_at_bound = up_down ? (r_count == c_MAX) : (r_count == c_ZERO);

    assign terminal_count = enable & ~load & ~clear & w_at_bound;

    // Next-state selection: clear beats load beats count beats hold.
    always_comb begin
        w_count_nxt   = r_count;
        w_wrapped_nxt = r_wrapped;
        if (clear) begin
            w_count_nxt   = c_ZERO;
            w_wrapped_nxt = 1'b0;
        end else if (load) begin
            w_count_nxt   = w_load_val;
            w_wrapped_nxt = 1'b0;
        end else if (enable) begin
            if (w_at_bound) begin
                if (!w_sat) begin
                    w_count_nxt   = up_down ? c_ZERO : c_MAX;
                    w_wrapped_nxt = 1'b1;
                end
            end else begin
                w_count_nxt = up_down ? (r_count + c_ONE) : (r_count - c_ONE);
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count   <= c_ZERO;
            r_wrapped <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_wrapped <= w_wrapped_nxt;
        end
    end

    assign result  = r_count;
    assign wrapped = r_wrapped;

endmodule
`default_nettype wire
